// File: rtl/mux_pkg.sv
// Shared constants and helpers for the mux_arb channel multiplexer.
package mux_pkg;

  localparam int unsigned DEF_WIDTH    = 8;
  localparam int unsigned DEF_CHANNELS = 4;

  // Width of a channel index for n channels (n >= 2).
  function automatic int unsigned chan_idx_w(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/mux_arb_grant.sv
// Grant generation for mux_arb: rotating-start priority search plus forced select.
// With ptr tied to zero the search degenerates to fixed lowest-index priority.
module mux_arb_grant
  import mux_pkg::*;
#(
  parameter int unsigned CHANNELS = DEF_CHANNELS,
  parameter int unsigned SELW     = chan_idx_w(CHANNELS)
) (
  input  logic [CHANNELS-1:0] valid,
  input  logic [SELW-1:0]     ptr,
  input  logic                force_en,
  input  logic [SELW-1:0]     force_sel,
  output logic [CHANNELS-1:0] grant_c,
  output logic [SELW-1:0]     grant_idx_c,
  output logic                grant_any_c
);

  // One-hot grant: forced channel if requested, else first valid from ptr.
  always_comb begin
    int unsigned c;
    grant_c     = '0;
    grant_idx_c = '0;
    grant_any_c = 1'b0;
    c           = 0;
    if (force_en) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if ((32'(force_sel) == i) && valid[SELW'(i)]) begin
          grant_c[SELW'(i)] = 1'b1;
          grant_idx_c       = SELW'(i);
          grant_any_c       = 1'b1;
        end
      end
    end else begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        c = 32'(ptr) + k;
        if (c >= CHANNELS) c = c - CHANNELS;
        if (!grant_any_c && valid[SELW'(c)]) begin
          grant_c[SELW'(c)] = 1'b1;
          grant_idx_c       = SELW'(c);
          grant_any_c       = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mux_arb.sv
// Registered N:1 channel multiplexer with valid/ready handshakes and built-in arbiter.
// Build option: define RR_ARB_EN for round-robin arbitration; otherwise fixed
// lowest-index priority with no pointer register.
module mux_arb
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned CHANNELS = DEF_CHANNELS,
  parameter int unsigned SELW     = chan_idx_w(CHANNELS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CHANNELS*WIDTH-1:0]    in_data,
  input  logic [CHANNELS-1:0]          in_valid,
  output logic [CHANNELS-1:0]          in_ready,
  input  logic                         force_en,
  input  logic [SELW-1:0]              force_sel,
  output logic [WIDTH-1:0]             out_data,
  output logic [SELW-1:0]              out_chan,
  output logic                         out_valid,
  input  logic                         out_ready
);

  logic                load_c;
  logic                xfer_c;
  logic [CHANNELS-1:0] grant_c;
  logic [SELW-1:0]     grant_idx_c;
  logic                grant_any_c;
  logic [WIDTH-1:0]    sel_data_c;
  logic [SELW-1:0]     ptr;

  mux_arb_grant #(
    .CHANNELS (CHANNELS),
    .SELW     (SELW)
  ) u_grant (
    .valid       (in_valid),
    .ptr         (ptr),
    .force_en    (force_en),
    .force_sel   (force_sel),
    .grant_c     (grant_c),
    .grant_idx_c (grant_idx_c),
    .grant_any_c (grant_any_c)
  );

  // Buffer can take a word when empty or draining this cycle.
  assign load_c   = !out_valid || out_ready;
  assign xfer_c   = rst_n && load_c && grant_any_c;
  assign in_ready = (rst_n && load_c) ? grant_c : '0;

  // Word from the granted channel; data never feeds the ready path.
  always_comb begin
    sel_data_c = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (grant_c[SELW'(i)]) sel_data_c = in_data[i*WIDTH +: WIDTH];
    end
  end

`ifdef RR_ARB_EN
  // Round-robin pointer: advance past the winner of each non-forced transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (xfer_c && !force_en) begin
      ptr <= (grant_idx_c == SELW'(CHANNELS - 1)) ? '0 : grant_idx_c + SELW'(1);
    end
  end
`else
  // Fixed priority: search always starts at channel 0.
  assign ptr = '0;
`endif

  // One-entry output buffer; holds on stall, empties when nothing is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_chan  <= '0;
      out_valid <= 1'b0;
    end else if (load_c) begin
      out_valid <= xfer_c;
      if (xfer_c) begin
        out_data <= sel_data_c;
        out_chan <= grant_idx_c;
      end
    end
  end

endmodule
